// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the 5-stage pipeline datapath and its hazard controller.
//   Pipeline -> controller : stage register indices, valid/halt/load/branch
//                            flags, active-low write enables, data-memory
//                            request/acknowledge.
//   Controller -> pipeline : per-register hold (WEN_*), PC hold, bubble
//                            squash, EX operand forwarding selects, sticky
//                            status and performance counters.
// modport master : the hazard controller
// modport slave  : the pipeline datapath
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1_id, Rs2_id;
  logic             valid_id, halt_id;
  logic [4:0]       Rs1_ex, Rs2_ex, Rdst_ex;
  logic             valid_ex, Load_ex, BranchTaken_ex;
  logic             RWrEn_ex, RWrEn_mem, RWrEn_wb;
  logic [4:0]       Rdst_mem, Rdst_wb;
  logic             valid_mem, valid_wb, halt_wb;
  logic             DMemReq, DMemAck;

  logic             WEN_ifid, WEN_idex, WEN_exmem, WEN_memwb;
  logic             PC_hold;
  logic             squash_ifid, squash_idex;
  logic [1:0]       FwdA_sel, FwdB_sel;
  logic             halted, mem_err;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

  modport master (
    input  Rs1_id, Rs2_id, valid_id, halt_id,
    input  Rs1_ex, Rs2_ex, Rdst_ex, valid_ex, Load_ex, BranchTaken_ex,
    input  RWrEn_ex, RWrEn_mem, RWrEn_wb, Rdst_mem, Rdst_wb,
    input  valid_mem, valid_wb, halt_wb, DMemReq, DMemAck,
    output WEN_ifid, WEN_idex, WEN_exmem, WEN_memwb, PC_hold,
    output squash_ifid, squash_idex, FwdA_sel, FwdB_sel,
    output halted, mem_err, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    output Rs1_id, Rs2_id, valid_id, halt_id,
    output Rs1_ex, Rs2_ex, Rdst_ex, valid_ex, Load_ex, BranchTaken_ex,
    output RWrEn_ex, RWrEn_mem, RWrEn_wb, Rdst_mem, Rdst_wb,
    output valid_mem, valid_wb, halt_wb, DMemReq, DMemAck,
    input  WEN_ifid, WEN_idex, WEN_exmem, WEN_memwb, PC_hold,
    input  squash_ifid, squash_idex, FwdA_sel, FwdB_sel,
    input  halted, mem_err, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for a 5-stage pipeline. Produces hold and
// squash controls for the IF/ID, ID/EX, EX/MEM, MEM/WB registers and the PC,
// EX-stage forwarding selects, halt drain tracking, a data-memory wait
// watchdog and cycle/stall/flush counters.
// Ports:
//   CLK : state updates on posedge (pipeline registers capture on negedge)
//   RST : synchronous, active-low
//   hz  : pipe_hazard_ctrl_if.master, all hazard inputs and control outputs
// Hazard outputs are purely combinational from hz inputs and current state.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  pipe_hazard_ctrl_if.master hz
);

  typedef enum logic [2:0] {RUN, MWAIT, DRAIN, HALTED, ERR} state_t;

  // One spare bit so the incremented count can never wrap before compare.
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1) + 1;

  state_t             state, state_nxt;
  logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
  logic [CNT_W-1:0]   cycle_cnt, stall_cnt, flush_cnt;

  logic mem_wait, load_use, active, flush_evt;
  logic wen_ifid, wen_idex, wen_exmem, wen_memwb, pc_hold;
  logic squash_ifid, squash_idex;
  logic [1:0] fwd_a, fwd_b;

  // MEM result wins over WB; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       v_mem, input logic wn_mem, input logic [4:0] d_mem,
    input logic       v_wb,  input logic wn_wb,  input logic [4:0] d_wb
  );
    if (v_mem && !wn_mem && d_mem != 5'd0 && d_mem == rs) return 2'b01;
    if (v_wb  && !wn_wb  && d_wb  != 5'd0 && d_wb  == rs) return 2'b10;
    return 2'b00;
  endfunction

  assign mem_wait = hz.DMemReq && !hz.DMemAck;
  assign load_use = hz.valid_ex && hz.Load_ex && !hz.RWrEn_ex &&
                    hz.Rdst_ex != 5'd0 &&
                    (hz.Rdst_ex == hz.Rs1_id || hz.Rdst_ex == hz.Rs2_id);
  assign active   = RST && state != HALTED && state != ERR;

  always_comb begin
    wen_ifid    = 1'b0;
    wen_idex    = 1'b0;
    wen_exmem   = 1'b0;
    wen_memwb   = 1'b0;
    pc_hold     = 1'b0;
    squash_ifid = 1'b0;
    squash_idex = 1'b0;
    flush_evt   = 1'b0;
    state_nxt   = state;
    wcnt_nxt    = '0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (RST) begin
      fwd_a = fwd_sel(hz.Rs1_ex, hz.valid_mem, hz.RWrEn_mem, hz.Rdst_mem,
                      hz.valid_wb, hz.RWrEn_wb, hz.Rdst_wb);
      fwd_b = fwd_sel(hz.Rs2_ex, hz.valid_mem, hz.RWrEn_mem, hz.Rdst_mem,
                      hz.valid_wb, hz.RWrEn_wb, hz.Rdst_wb);
      case (state)
        HALTED, ERR: begin
          {wen_ifid, wen_idex, wen_exmem, wen_memwb, pc_hold} = 5'b11111;
        end
        default: begin
          if (mem_wait) begin
            // Full freeze. The watchdog also runs while draining so a lost
            // ack cannot hang a halt forever. DRAIN/MWAIT hold their state.
            {wen_ifid, wen_idex, wen_exmem, wen_memwb, pc_hold} = 5'b11111;
            wcnt_nxt = wcnt + WCNT_W'(1);
            if (wcnt_nxt >= WCNT_W'(MEM_TIMEOUT)) state_nxt = ERR;
            else if (state == RUN)                 state_nxt = MWAIT;
          end else if (hz.BranchTaken_ex) begin
            // Branch is older than anything in IF/ID, including a halt.
            squash_ifid = 1'b1;
            squash_idex = 1'b1;
            flush_evt   = 1'b1;
            state_nxt   = RUN;
          end else if (state == DRAIN) begin
            pc_hold     = 1'b1;
            squash_ifid = 1'b1;
            if (hz.valid_wb && hz.halt_wb) state_nxt = HALTED;
          end else begin
            // RUN, or the MWAIT cycle in which the ack arrives.
            state_nxt = RUN;
            if (load_use) begin
              pc_hold     = 1'b1;
              wen_ifid    = 1'b1;
              squash_idex = 1'b1;
            end else if (hz.valid_id && hz.halt_id) begin
              state_nxt = DRAIN;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= RUN;
      wcnt      <= '0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (active)            cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (active && pc_hold) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt)         flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.WEN_ifid    = wen_ifid;
  assign hz.WEN_idex    = wen_idex;
  assign hz.WEN_exmem   = wen_exmem;
  assign hz.WEN_memwb   = wen_memwb;
  assign hz.PC_hold     = pc_hold;
  assign hz.squash_ifid = squash_ifid;
  assign hz.squash_idex = squash_idex;
  assign hz.FwdA_sel    = fwd_a;
  assign hz.FwdB_sel    = fwd_b;
  assign hz.halted      = state == HALTED || state == ERR;
  assign hz.mem_err     = state == ERR;
  assign hz.cycle_cnt   = cycle_cnt;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4). Inputs change 1 time
// unit after each posedge; outputs are checked at the following negedge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_cyc = 0;
  bit   frz = 1'b0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle counter reference: counts posedges taken out of reset while the
  // controller is expected to be running.
  task automatic tick;
    @(posedge CLK);
    if (RST && !frz) exp_cyc++;
    #1;
  endtask

  task automatic settle;
    @(negedge CLK);
  endtask

  task automatic clr;
    hz.Rs1_id = 0; hz.Rs2_id = 0; hz.valid_id = 0; hz.halt_id = 0;
    hz.Rs1_ex = 0; hz.Rs2_ex = 0; hz.Rdst_ex = 0;
    hz.valid_ex = 0; hz.Load_ex = 0; hz.BranchTaken_ex = 0;
    hz.RWrEn_ex = 1; hz.RWrEn_mem = 1; hz.RWrEn_wb = 1;
    hz.Rdst_mem = 0; hz.Rdst_wb = 0;
    hz.valid_mem = 0; hz.valid_wb = 0; hz.halt_wb = 0;
    hz.DMemReq = 0; hz.DMemAck = 0;
  endtask

  task automatic set_load_use;
    hz.valid_ex = 1; hz.Load_ex = 1; hz.RWrEn_ex = 0; hz.Rdst_ex = 7;
    hz.valid_id = 1; hz.Rs2_id = 7;
  endtask

  function automatic logic [3:0] wens;
    return {hz.WEN_ifid, hz.WEN_idex, hz.WEN_exmem, hz.WEN_memwb};
  endfunction

  initial begin
    // Reset with hazards present: outputs must stay idle.
    clr();
    hz.DMemReq = 1; hz.valid_mem = 1; hz.RWrEn_mem = 0; hz.Rdst_mem = 5;
    hz.Rs1_ex = 5;
    tick(); tick(); settle();
    chk("rst_wen", {28'd0, wens()}, 32'h0);
    chk("rst_pc_hold", hz.PC_hold, 0);
    chk("rst_fwda", hz.FwdA_sel, 0);
    chk("rst_cycle", hz.cycle_cnt, 0);
    chk("rst_stall", hz.stall_cnt, 0);
    chk("rst_status", {hz.halted, hz.mem_err}, 0);
    tick();

    // Forwarding.
    RST = 1; hz.DMemReq = 0;
    hz.valid_wb = 1; hz.RWrEn_wb = 0; hz.Rdst_wb = 5;
    settle();
    chk("fwd_mem_prio", hz.FwdA_sel, 2'b01);
    hz.Rdst_mem = 0; hz.Rs2_ex = 5; #1;
    chk("fwda_wb", hz.FwdA_sel, 2'b10);
    chk("fwdb_wb", hz.FwdB_sel, 2'b10);
    hz.Rs1_ex = 0; hz.Rdst_wb = 0; #1;
    chk("fwd_x0", hz.FwdA_sel, 2'b00);
    tick();

    // Load-use: one bubble, then value forwarded from WB.
    clr(); set_load_use(); settle();
    chk("lu_pc_hold", hz.PC_hold, 1);
    chk("lu_ctl", {hz.WEN_ifid, hz.squash_idex, hz.squash_ifid, hz.WEN_idex},
        4'b1100);
    tick();
    clr(); hz.valid_mem = 1; hz.RWrEn_mem = 0; hz.Rdst_mem = 7;
    hz.valid_id = 1; hz.Rs2_id = 7; settle();
    chk("lu_once", hz.PC_hold, 0);
    chk("lu_stall_cnt", hz.stall_cnt, 1);
    tick();
    clr(); hz.valid_wb = 1; hz.RWrEn_wb = 0; hz.Rdst_wb = 7;
    hz.valid_ex = 1; hz.Rs2_ex = 7; settle();
    chk("lu_fwdb", hz.FwdB_sel, 2'b10);
    tick();

    // Branch overrides load-use.
    clr(); set_load_use(); hz.BranchTaken_ex = 1; settle();
    chk("br_squash", {hz.squash_ifid, hz.squash_idex}, 2'b11);
    chk("br_no_hold", {hz.PC_hold, hz.WEN_ifid}, 2'b00);
    tick();
    clr(); settle();
    chk("br_flush_cnt", hz.flush_cnt, 1);
    chk("br_stall_cnt", hz.stall_cnt, 1);
    tick();

    // Memory wait of 3 cycles, branch pending during the wait.
    clr(); hz.DMemReq = 1; settle();
    chk("mw1_wen", {28'd0, wens()}, 32'hf);
    chk("mw1_hold_sq", {hz.PC_hold, hz.squash_ifid, hz.squash_idex}, 3'b100);
    tick(); settle();
    chk("mw2_wen", {28'd0, wens()}, 32'hf);
    tick(); hz.BranchTaken_ex = 1; settle();
    chk("mw3_wen", {28'd0, wens()}, 32'hf);
    chk("mw3_no_squash", {hz.squash_ifid, hz.squash_idex}, 2'b00);
    tick(); hz.DMemAck = 1; settle();
    chk("mw_ack_wen", {27'd0, wens(), hz.PC_hold}, 32'h0);
    chk("mw_ack_branch", {hz.squash_ifid, hz.squash_idex}, 2'b11);
    tick();
    clr(); settle();
    chk("mw_stall_cnt", hz.stall_cnt, 4);
    chk("mw_flush_cnt", hz.flush_cnt, 2);
    chk("mw_status", {hz.halted, hz.mem_err}, 0);
    tick();

    // Halt drain.
    clr(); hz.valid_id = 1; hz.halt_id = 1; settle();
    chk("h0_no_hold", hz.PC_hold, 0);
    tick();
    clr(); settle();
    chk("h1_drain", {hz.PC_hold, hz.squash_ifid}, 2'b11);
    tick(); settle();
    chk("h2_drain", {hz.PC_hold, hz.squash_ifid}, 2'b11);
    tick(); hz.valid_wb = 1; hz.halt_wb = 1; settle();
    chk("h3_drain", {hz.squash_ifid, hz.halted}, 2'b10);
    tick(); frz = 1;
    clr(); settle();
    chk("halted", {hz.halted, hz.mem_err}, 2'b10);
    chk("halted_hold", {27'd0, wens(), hz.PC_hold}, 32'h1f);
    chk("halted_cycle", hz.cycle_cnt, exp_cyc);
    tick(); tick(); settle();
    chk("halted_cycle_frozen", hz.cycle_cnt, exp_cyc);
    chk("halted_stall_cnt", hz.stall_cnt, 7);
    tick();

    // Reset out of HALTED.
    RST = 0; settle();
    chk("rst_halted_idle", {27'd0, wens(), hz.PC_hold}, 32'h0);
    tick();
    RST = 1; frz = 0; exp_cyc = 0; settle();
    chk("rst2_status", hz.halted, 0);
    chk("rst2_cnt", hz.cycle_cnt | hz.stall_cnt | hz.flush_cnt, 0);
    tick();

    // Halt together with a taken branch stays in RUN.
    clr(); hz.valid_id = 1; hz.halt_id = 1; hz.BranchTaken_ex = 1; settle();
    chk("hb_squash", {hz.squash_ifid, hz.squash_idex}, 2'b11);
    tick();
    clr(); settle();
    chk("hb_run", {hz.PC_hold, hz.squash_ifid}, 2'b00);
    chk("hb_flush", hz.flush_cnt, 1);
    tick();

    // Taken branch in DRAIN returns to RUN.
    clr(); hz.valid_id = 1; hz.halt_id = 1; settle();
    tick();
    clr(); hz.BranchTaken_ex = 1; settle();
    chk("db_branch", {hz.PC_hold, hz.squash_ifid, hz.squash_idex}, 3'b011);
    tick();
    clr(); settle();
    chk("db_run", {hz.PC_hold, hz.squash_ifid}, 2'b00);
    tick();

    // Reset mid-MWAIT, then watchdog timeout with MEM_TIMEOUT = 4.
    clr(); hz.DMemReq = 1; settle();
    tick(); settle();
    chk("mw_pre_rst", {28'd0, wens()}, 32'hf);
    tick(); RST = 0; settle();
    chk("mw_rst_idle", {27'd0, wens(), hz.PC_hold}, 32'h0);
    tick();
    RST = 1; exp_cyc = 0; settle();
    chk("mw_rst_cnt", hz.cycle_cnt | hz.stall_cnt | hz.flush_cnt, 0);
    chk("to_w1_wen", {28'd0, wens()}, 32'hf);
    tick(); tick(); tick(); settle();
    chk("to_w4_no_err", {hz.halted, hz.mem_err}, 2'b00);
    tick(); frz = 1; settle();
    chk("to_err", {hz.halted, hz.mem_err}, 2'b11);
    chk("to_err_hold", {27'd0, wens(), hz.PC_hold}, 32'h1f);
    tick(); settle();
    chk("to_cycle_frozen", hz.cycle_cnt, exp_cyc);
    chk("to_stall_cnt", hz.stall_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipeline. It computes per-stage hold (WEN) and squash controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC hold. It also selects EX-stage operand forwarding and tracks halt drain and data-memory wait with a watchdog. It keeps cycle, stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum consecutive data-memory wait cycles before error.
- CNT_W, 32: performance counter width.

Ports:
- CLK  in  1  clock; this block's state updates on posedge, pipeline registers capture on negedge.
- RST  in  1  reset, synchronous, active-low.
- Rs1_id, Rs2_id  in  5  source registers of the instruction in ID.
- valid_id, halt_id  in  1  ID-stage valid and halt flags.
- Rs1_ex, Rs2_ex, Rdst_ex  in  5  EX-stage sources and destination.
- valid_ex, Load_ex, BranchTaken_ex  in  1  EX valid; EX is a load; EX branch/JMP resolved taken.
- RWrEn_ex, RWrEn_mem, RWrEn_wb  in  1  active-low register write enables (0 = writes).
- Rdst_mem, Rdst_wb  in  5  MEM and WB destinations.
- valid_mem, valid_wb, halt_wb  in  1  stage valid flags; halt has reached WB.
- DMemReq  in  1  MEM stage is accessing data memory.
- DMemAck  in  1  data memory completes the access this cycle.
- WEN_ifid, WEN_idex, WEN_exmem, WEN_memwb  out  1  1 = hold register.
- PC_hold  out  1  1 = PC not updated.
- squash_ifid, squash_idex  out  1  1 = insert NOP (32'h00000013) bubble.
- FwdA_sel, FwdB_sel  out  2  00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value.
- halted, mem_err  out  1  sticky status.
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- States: RUN, MWAIT, DRAIN, HALTED, ERR. Reset goes to RUN.
- Reset values (RST low at posedge): state RUN; wait counter 0; all counters 0; halted 0; mem_err 0.
- While RST is low, all combinational outputs are forced idle: WEN_* 0, PC_hold 0, squash_* 0, Fwd*_sel 00.
- **Forwarding** (combinational, all states), computed per operand Rs of EX:
  - 01 if valid_mem, !RWrEn_mem, Rdst_mem!=0 and Rdst_mem==Rs.
  - Otherwise 10 if the same conditions hold for WB.
  - Otherwise 00. MEM has priority over WB. x0 is never forwarded.
- **Load-use**: valid_ex, Load_ex, !RWrEn_ex, Rdst_ex!=0, and Rdst_ex equals Rs1_id or Rs2_id.
  - Response: PC_hold=1, WEN_ifid=1, squash_idex=1.
- **Branch**: BranchTaken_ex gives squash_ifid=1 and squash_idex=1. Branch overrides load-use in the same cycle.
- **Memory wait**: DMemReq && !DMemAck freezes the pipeline.
  - All WEN_*=1 and PC_hold=1; no squash asserted.
  - This has the highest priority among hazards; a pending branch or load-use is acted on in the cycle ack arrives.
  - State RUN→MWAIT when the wait begins; the wait counter increments each MWAIT cycle.
  - MWAIT→RUN on DMemAck.
  - MWAIT→ERR when the counter reaches MEM_TIMEOUT.
- **Halt**:
  - valid_id && halt_id in RUN (no stall, no taken branch) → DRAIN.
  - DRAIN: PC_hold=1, squash_ifid=1 every cycle.
  - DRAIN→HALTED on valid_wb && halt_wb.
  - A taken branch in DRAIN (older than the halt) → RUN.
  - Memory wait inside DRAIN freezes the pipeline as usual but stays in DRAIN.
- **HALTED / ERR**: all WEN_*=1 and PC_hold=1; halted=1 (both states) and mem_err=1 (ERR). Both persist until reset.
- **Counters** wrap modulo 2^CNT_W:
  - cycle_cnt increments every non-reset cycle except in HALTED/ERR.
  - stall_cnt increments in any cycle with PC_hold=1 in RUN/MWAIT/DRAIN.
  - flush_cnt increments on each taken-branch squash.

## Timing
- Hazard outputs are combinational from inputs and state. They must settle within the high phase so negedge register capture sees them.
- Load-use costs exactly 1 bubble; the consumer reads the load value via FwdSel=10 on the next EX cycle.
- A taken branch costs exactly 2 bubbles.
- A memory wait of N cycles freezes the pipeline for N cycles. Release happens in the same cycle DMemAck=1, with zero extra latency.
- halted rises 1 posedge after halt_wb is seen in DRAIN. mem_err rises on the posedge at which the count reaches MEM_TIMEOUT.
- Reset asserted mid-MWAIT or mid-DRAIN: next posedge returns to RUN and clears counters.

## Test plan
- EX: Rdst_mem=5 (writes); WB: Rdst_wb=5 (writes); Rs1_ex=5 → FwdA_sel=01. With Rdst_mem=0 instead → FwdA_sel=10.
- Load_ex=1, Rdst_ex=7, Rs2_id=7 → exactly one cycle of PC_hold=1, WEN_ifid=1, squash_idex=1; stall_cnt=1.
- BranchTaken_ex=1 together with a load-use condition → squash_ifid=squash_idex=1, PC_hold=0; flush_cnt +1.
- DMemReq=1, ack after 3 cycles → all WEN_* high for 3 cycles, low in the ack cycle. With MEM_TIMEOUT=4 and no ack → mem_err=1 and halted=1 after 4 wait cycles.
- halt_id in RUN, then halt_wb 3 cycles later → DRAIN with squash_ifid each cycle, then halted=1 and cycle_cnt frozen. halt_id alongside BranchTaken_ex → stays RUN.
- RST low for one posedge during MWAIT → state RUN, all counters 0, outputs idle.
